// File: rtl/counter_bus_master.sv
// rtl/counter_bus_master.sv - host command sequencer driving a counter block over a register bus
//
// Purpose:
//   Accepts one host command at a time, turns it into a fixed sequence of
//   register bus writes, finishes every command with a status read and returns
//   the sampled count/overflow as a response.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only in IDLE)
//   cmd_op[1:0]             00 PULSE, 01 READ, 10 CLR_COUNT, 11 CLR_OVF
//   cmd_num[3:0]            pulse count for PULSE
//   rsp_valid/rsp_ready     response handshake
//   rsp_count[2:0], rsp_ovf status sampled by the final read
//   bus_wr_en, bus_rd_en    registered bus strobes (never both high)
//   bus_addr[9:0]           registered bus address
//   bus_wdata[31:0]         registered bus write data
//   bus_rdata[31:0]         read data, combinational from target while bus_rd_en=1
module counter_bus_master #(
  parameter logic [9:0] ADDR_CR = 10'h000,
  parameter logic [9:0] ADDR_SR = 10'h004
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_num,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [2:0]  rsp_count,
  output logic        rsp_ovf,
  output logic        bus_wr_en,
  output logic        bus_rd_en,
  output logic [9:0]  bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] OP_PULSE     = 2'b00;
  localparam logic [1:0] OP_READ      = 2'b01;
  localparam logic [1:0] OP_CLR_COUNT = 2'b10;
  localparam logic [1:0] OP_CLR_OVF   = 2'b11;

  typedef enum logic [2:0] {
    IDLE, P_HI, P_LO, CLR_SET, CLR_REL, OVF_CLR, RD, RSP
  } state_t;

  state_t      state, next_state;
  logic [3:0]  pulse_cnt, next_pulse_cnt;
  logic        nxt_wr_en, nxt_rd_en;
  logic [9:0]  nxt_addr;
  logic [31:0] nxt_wdata;

  // Only the low nibble of the status word carries information.
  logic unused_rdata;
  assign unused_rdata = ^bus_rdata[31:4];

  // Gated by rst_n so the host never sees ready while reset is held.
  assign cmd_ready = rst_n && (state == IDLE);
  assign rsp_valid = (state == RSP);

  always_comb begin
    next_state     = state;
    next_pulse_cnt = pulse_cnt;
    nxt_wr_en      = 1'b0;
    nxt_rd_en      = 1'b0;
    nxt_addr       = ADDR_CR;
    nxt_wdata      = 32'h0;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_PULSE: begin
              next_pulse_cnt = cmd_num;
              next_state     = (cmd_num == 4'd0) ? RD : P_HI;
            end
            OP_READ:      next_state = RD;
            OP_CLR_COUNT: next_state = CLR_SET;
            OP_CLR_OVF:   next_state = OVF_CLR;
            default:      next_state = IDLE;
          endcase
        end
      end
      P_HI: next_state = P_LO;
      P_LO: begin
        // Counter saturates at zero; the last pulse leaves for the status read.
        next_pulse_cnt = (pulse_cnt == 4'd0) ? 4'd0 : pulse_cnt - 4'd1;
        next_state     = (pulse_cnt <= 4'd1) ? RD : P_HI;
      end
      CLR_SET: next_state = CLR_REL;
      CLR_REL: next_state = RD;
      OVF_CLR: next_state = RD;
      RD:      next_state = RSP;
      RSP:     if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase

    // Bus outputs are decoded from the state being entered so that, once
    // registered, they line up exactly with that state's cycle.
    case (next_state)
      P_HI: begin
        nxt_wr_en = 1'b1;
        nxt_wdata = 32'h1;
      end
      CLR_SET: begin
        nxt_wr_en = 1'b1;
        nxt_wdata = 32'h2;
      end
      CLR_REL: begin
        nxt_wr_en = 1'b1;
        nxt_wdata = 32'h0;
      end
      OVF_CLR: begin
        nxt_wr_en = 1'b1;
        nxt_addr  = ADDR_SR;
        nxt_wdata = 32'h0;
      end
      RD: begin
        nxt_rd_en = 1'b1;
        nxt_addr  = ADDR_SR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pulse_cnt <= 4'd0;
      bus_wr_en <= 1'b0;
      bus_rd_en <= 1'b0;
      bus_addr  <= ADDR_CR;
      bus_wdata <= 32'h0;
      rsp_count <= 3'd0;
      rsp_ovf   <= 1'b0;
    end else begin
      state     <= next_state;
      pulse_cnt <= next_pulse_cnt;
      bus_wr_en <= nxt_wr_en;
      bus_rd_en <= nxt_rd_en;
      bus_addr  <= nxt_addr;
      bus_wdata <= nxt_wdata;
      // Raw status is passed through untouched, including wrap/overflow.
      if (state == RD) begin
        rsp_count <= bus_rdata[2:0];
        rsp_ovf   <= bus_rdata[3];
      end
    end
  end

endmodule

// File: tb/tb_counter_bus_master.sv
// tb/tb_counter_bus_master.sv - directed self-checking bench for counter_bus_master
module tb_counter_bus_master;

  localparam logic [9:0] CR = 10'h000;
  localparam logic [9:0] SR = 10'h004;
  localparam logic [1:0] OP_PULSE = 2'b00, OP_READ = 2'b01, OP_CLRC = 2'b10, OP_CLRO = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [3:0]  cmd_num = 4'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [2:0]  rsp_count;
  logic        rsp_ovf;
  logic        bus_wr_en, bus_rd_en;
  logic [9:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;

  counter_bus_master #(.ADDR_CR(CR), .ADDR_SR(SR)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_num(cmd_num),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_count(rsp_count), .rsp_ovf(rsp_ovf),
    .bus_wr_en(bus_wr_en), .bus_rd_en(bus_rd_en), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // Target counter block: CR bit0 write counts one pulse (7->0 wraps and sets
  // overflow), CR bit1 clears count, SR write loads overflow from wdata[3].
  logic [2:0] t_cnt = 3'd0;
  logic       t_ovf = 1'b0;
  always @(posedge clk) begin
    if (bus_wr_en && bus_addr == CR) begin
      if (bus_wdata[1]) t_cnt <= 3'd0;
      else if (bus_wdata[0]) begin
        if (t_cnt == 3'd7) t_ovf <= 1'b1;
        t_cnt <= t_cnt + 3'd1;
      end
    end else if (bus_wr_en && bus_addr == SR) begin
      t_ovf <= bus_wdata[3];
    end
  end
  assign bus_rdata = bus_rd_en ? {28'h0, t_ovf, t_cnt} : 32'hFFFF_FFFF;

  int n_tests = 0;
  int n_fail  = 0;
  int both_cnt = 0;
  always @(negedge clk) if (bus_wr_en && bus_rd_en) both_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int          g_lat, g_nwr, g_nrd;
  logic [9:0]  g_waddr [8];
  logic [31:0] g_wdata [8];
  int          g_wcyc  [8];
  logic [2:0]  g_rc;
  logic        g_ro;

  // Issue one command, log bus activity until rsp_valid; g_lat counts sampled
  // cycles after the accepting edge. hold>0 keeps rsp_ready low that long
  // while a competing command is presented.
  task automatic do_cmd(input logic [1:0] op, input logic [3:0] num, input int hold);
    int w;
    int stall_bad;
    logic [2:0] rc0;
    logic ro0;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
    check("cmd_ready_wait", {31'h0, cmd_ready}, 32'h1);
    cmd_valid = 1'b1; cmd_op = op; cmd_num = num; rsp_ready = (hold == 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    g_lat = 1; g_nwr = 0; g_nrd = 0;
    while (!rsp_valid && g_lat < 40) begin
      if (bus_wr_en && g_nwr < 8) begin
        g_waddr[g_nwr] = bus_addr; g_wdata[g_nwr] = bus_wdata; g_wcyc[g_nwr] = g_lat;
        g_nwr++;
      end
      if (bus_rd_en) g_nrd++;
      @(negedge clk);
      g_lat++;
    end
    check("rsp_valid_timeout", {31'h0, rsp_valid}, 32'h1);
    if (hold > 0) begin
      rc0 = rsp_count; ro0 = rsp_ovf; stall_bad = 0;
      for (int i = 0; i < hold; i++) begin
        cmd_valid = 1'b1; cmd_op = OP_PULSE; cmd_num = 4'd3;
        @(negedge clk);
        if (!rsp_valid || rsp_count !== rc0 || rsp_ovf !== ro0 || cmd_ready || bus_wr_en || bus_rd_en)
          stall_bad++;
      end
      cmd_valid = 1'b0; rsp_ready = 1'b1;
      check("stall_hold", stall_bad, 0);
    end
    g_rc = rsp_count; g_ro = rsp_ovf;
    @(negedge clk);
    check("rsp_dropped", {31'h0, rsp_valid}, 32'h0);
    check("back_idle", {31'h0, cmd_ready}, 32'h1);
  endtask

  initial begin
    int strobes;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp", {28'h0, rsp_ovf, rsp_count}, 32'h0);
    check("rst_bus_en", {30'h0, bus_wr_en, bus_rd_en}, 32'h0);
    check("rst_bus_addr", {22'h0, bus_addr}, {22'h0, CR});
    check("rst_bus_wdata", bus_wdata, 32'h0);
    rst_n = 1'b1;
    #1 check("ready_after_rst", {31'h0, cmd_ready}, 32'h1);

    // PULSE N=1
    do_cmd(OP_PULSE, 4'd1, 0);
    check("p1_nwr", g_nwr, 1);
    check("p1_waddr", {22'h0, g_waddr[0]}, {22'h0, CR});
    check("p1_wdata", g_wdata[0], 32'h1);
    check("p1_nrd", g_nrd, 1);
    check("p1_lat", g_lat, 4);
    check("p1_rsp", {28'h0, g_ro, g_rc}, 32'h1);

    // PULSE N=3 then N=2
    do_cmd(OP_PULSE, 4'd3, 0);
    check("p3_nwr", g_nwr, 3);
    check("p3_gap01", g_wcyc[1] - g_wcyc[0], 2);
    check("p3_gap12", g_wcyc[2] - g_wcyc[1], 2);
    check("p3_lat", g_lat, 8);
    check("p3_rsp", {28'h0, g_ro, g_rc}, 32'h4);
    do_cmd(OP_PULSE, 4'd2, 0);
    check("p2_rsp", {28'h0, g_ro, g_rc}, 32'h6);

    // Wrap from 6 through 7 to 0 with overflow
    do_cmd(OP_PULSE, 4'd2, 0);
    check("wrap_rsp", {28'h0, g_ro, g_rc}, 32'h8);
    repeat (3) @(negedge clk);
    do_cmd(OP_READ, 4'd9, 0);
    check("rd_nwr", g_nwr, 0);
    check("rd_lat", g_lat, 2);
    check("rd_ovf_sticky", {28'h0, g_ro, g_rc}, 32'h8);
    do_cmd(OP_CLRO, 4'd0, 0);
    check("clro_nwr", g_nwr, 1);
    check("clro_waddr", {22'h0, g_waddr[0]}, {22'h0, SR});
    check("clro_wdata", g_wdata[0], 32'h0);
    check("clro_rsp", {28'h0, g_ro, g_rc}, 32'h0);

    // PULSE N=1 then CLR_COUNT
    do_cmd(OP_PULSE, 4'd1, 0);
    check("p1b_rsp", {28'h0, g_ro, g_rc}, 32'h1);
    do_cmd(OP_CLRC, 4'd0, 0);
    check("clrc_nwr", g_nwr, 2);
    check("clrc_w0", {g_waddr[0], g_wdata[0][21:0]}, {CR, 22'h2});
    check("clrc_w1", {g_waddr[1], g_wdata[1][21:0]}, {CR, 22'h0});
    check("clrc_lat", g_lat, 4);
    check("clrc_rsp", {28'h0, g_ro, g_rc}, 32'h0);

    // Response stall, then PULSE N=0
    do_cmd(OP_READ, 4'd0, 5);
    check("stall_rsp", {28'h0, g_ro, g_rc}, 32'h0);
    do_cmd(OP_PULSE, 4'd0, 0);
    check("p0_nwr", g_nwr, 0);
    check("p0_nrd", g_nrd, 1);
    check("p0_lat", g_lat, 2);

    // Reset during P_HI of PULSE N=5
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_PULSE; cmd_num = 4'd5;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("p5_in_phi", {31'h0, bus_wr_en}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("p5_rst_wr", {31'h0, bus_wr_en}, 32'h0);
    check("p5_rst_rsp", {31'h0, rsp_valid}, 32'h0);
    check("p5_rst_ready", {31'h0, cmd_ready}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("p5_ready_rel", {31'h0, cmd_ready}, 32'h1);
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_wr_en || bus_rd_en || rsp_valid) strobes++;
    end
    check("p5_no_strobes", strobes, 0);

    // Recovery after abandoned command
    do_cmd(OP_PULSE, 4'd1, 0);
    check("recover_rsp", {28'h0, g_ro, g_rc}, 32'h1);

    check("wr_rd_exclusive", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
